// File: rtl/ddr_req_queue_pkg.sv
// Shared types for the host request queue: request encodings, queue entry layout
// and issue FSM states.
package ddr_req_queue_pkg;

    localparam int unsigned ADDR_W_DEF = 40;

    typedef enum logic [1:0] {
        RD_R  = 2'd0,
        WR_R  = 2'd1,
        RDA_R = 2'd2,
        WRA_R = 2'd3
    } request_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        request_t              req;
    } req_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } queue_state_t;

endpackage

// File: rtl/ddr_req_queue_if.sv
// Host-side request bus and decoder-side command bus of the request queue.
interface ddr_req_queue_if
    import ddr_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic                     host_valid;
    logic                     host_ready;
    logic [ADDR_W-1:0]        host_addr;
    request_t                 host_req;
    logic                     busy;
    logic                     cmd_rdy;
    logic [ADDR_W-1:0]        log_addr;
    request_t                 request;
    logic [$clog2(DEPTH):0]   q_count;
    logic                     timeout;

    modport master (
        output host_valid, host_addr, host_req, busy,
        input  host_ready, cmd_rdy, log_addr, request, q_count, timeout
    );

    modport slave (
        input  host_valid, host_addr, host_req, busy,
        output host_ready, cmd_rdy, log_addr, request, q_count, timeout
    );
endinterface

// File: rtl/ddr_req_queue_fifo.sv
// Synchronous FIFO of request entries; occupancy is tracked by an explicit count so
// full/empty never depend on pointer equality.
module ddr_req_queue_fifo
    import ddr_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  req_entry_t               entry_i,
    input  logic                     pop_i,
    output req_entry_t               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    req_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    // Storage, pointers (wrapping naturally at a power-of-two depth) and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == CNT_W'(0));
    assign count_o = count_q;

endmodule

// File: rtl/ddr_req_queue.sv
// Host request queue feeding the command decoder: buffers requests and issues them one
// at a time, throttled by controller busy, a post-busy gap and a busy-rise timeout.
module ddr_req_queue
    import ddr_req_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned GAP_CYC = 4,
    parameter int unsigned BUSY_TO = 64
) (
    input  logic             CK_t,
    input  logic             reset_n,
    ddr_req_queue_if.slave   bus
);
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam int unsigned GAP_W   = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int unsigned TO_W    = $clog2(BUSY_TO + 1);
    // Loaded in ISSUE and first tested one cycle later, so timeout lands BUSY_TO cycles after cmd_rdy
    localparam int unsigned TO_LOAD = (BUSY_TO > 2) ? BUSY_TO - 2 : 0;

    queue_state_t       state_q;
    logic               cmd_rdy_q;
    logic [ADDR_W-1:0]  log_addr_q;
    request_t           request_q;
    logic               timeout_q;
    logic [GAP_W-1:0]   gap_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic               avail_q;

    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               host_ready_s;
    logic [CNT_W-1:0]   count_s;
    req_entry_t         entry_s;
    req_entry_t         head_s;

    assign host_ready_s = reset_n && !full_s;
    assign push_s       = bus.host_valid && host_ready_s;
    assign entry_s.addr = bus.host_addr;
    assign entry_s.req  = bus.host_req;

    // avail_q is a registered view of occupancy: a fresh entry becomes issuable on the
    // second edge after its push, and the FSM never pops twice within one refresh of it
    assign pop_s = (state_q == IDLE) && avail_q && !empty_s && !bus.busy && (gap_q == '0);

    ddr_req_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CK_t),
        .reset_n (reset_n),
        .push_i  (push_s),
        .entry_i (entry_s),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (count_s)
    );

    // Issue FSM with registered decoder outputs, gap counter and busy-rise watchdog
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cmd_rdy_q  <= 1'b0;
            log_addr_q <= '0;
            request_q  <= RD_R;
            timeout_q  <= 1'b0;
            gap_q      <= '0;
            to_cnt_q   <= '0;
            avail_q    <= 1'b0;
        end else begin
            avail_q <= !empty_s;
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        log_addr_q <= head_s.addr;
                        request_q  <= head_s.req;
                        cmd_rdy_q  <= 1'b1;
                        state_q    <= ISSUE;
                    end else begin
                        cmd_rdy_q <= 1'b0;
                        if (gap_q != '0) begin
                            gap_q <= gap_q - GAP_W'(1);
                        end else begin
                            gap_q <= gap_q;
                        end
                    end
                end
                ISSUE: begin
                    cmd_rdy_q <= 1'b0;
                    to_cnt_q  <= TO_W'(TO_LOAD);
                    state_q   <= WAIT_HI;
                end
                WAIT_HI: begin
                    cmd_rdy_q <= 1'b0;
                    if (bus.busy) begin
                        state_q <= WAIT_LO;
                    end else if (to_cnt_q == '0) begin
                        // Entry is dropped, not retried; the flag stays up until reset
                        timeout_q <= 1'b1;
                        gap_q     <= GAP_W'(GAP_CYC);
                        state_q   <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q - TO_W'(1);
                    end
                end
                WAIT_LO: begin
                    cmd_rdy_q <= 1'b0;
                    if (!bus.busy) begin
                        gap_q   <= GAP_W'(GAP_CYC);
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_LO;
                    end
                end
                default: begin
                    cmd_rdy_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.host_ready = host_ready_s;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.log_addr   = log_addr_q;
    assign bus.request    = request_q;
    assign bus.q_count    = count_s;
    assign bus.timeout    = timeout_q;

endmodule
